// File: rtl/custom_package.sv
// Shared types for the counter and the job scheduler that drives it.
// Holds direction/status/error enums, scheduler FSM states and defaults.
package custom_package;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } direction_t;

    typedef enum logic [1:0] {
        READY = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } status_t;

    typedef enum logic [1:0] {
        NO_ERR   = 2'd0,
        UP_ERR   = 2'd1,
        DOWN_ERR = 2'd2
    } err_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        REPORT = 2'd3
    } sched_state_t;

    localparam int default_timeout = 1024;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer.
// Ports: clk_i, rst_i (sync, high), req_i, adv_i (move pointer past grant),
//        gnt_o (one-hot), gnt_id_o (index of the grant).
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic             adv_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  gnt_id_o
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W:0]   idx;
    logic [ID_W:0]   nxt;
    logic            found;

    // Scan from the pointer, wrapping; one extra bit keeps ptr+i exact.
    always_comb begin
        gnt_o    = '0;
        gnt_id_o = '0;
        found    = 1'b0;
        idx      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (idx >= (ID_W+1)'(N_REQ)) begin
                idx = idx - (ID_W+1)'(N_REQ);
            end
            if (!found && req_i[idx[ID_W-1:0]]) begin
                found    = 1'b1;
                gnt_id_o = idx[ID_W-1:0];
            end
        end
        if (found) begin
            gnt_o[gnt_id_o] = 1'b1;
        end
    end

    always_comb begin
        nxt   = {1'b0, gnt_id_o} + (ID_W+1)'(1);
        ptr_d = ptr_q;
        if (adv_i && found) begin
            ptr_d = (nxt >= (ID_W+1)'(N_REQ)) ? '0 : nxt[ID_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cnt_job_scheduler.sv
// Shares one up_down_counter between N_REQ requesters: arbitrates jobs,
// drives the counter, returns a completion record over valid/ready.
// Ports: req_* (job in), cntr_* (counter ctl/status), done_* (record out),
//        busy. Optional RUN watchdog when CNT_SCHED_TIMEOUT_EN is defined.
module cnt_job_scheduler
    import custom_package::*;
#(
    parameter int N_REQ          = 4,
    parameter int ID_W           = $clog2(N_REQ),
    parameter int TIMEOUT_CYCLES = default_timeout
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ-1:0][31:0] req_start_val,
    input  logic [N_REQ-1:0][31:0] req_end_val,
    input  direction_t [N_REQ-1:0] req_direction,
    output logic                   cntr_en,
    output logic                   cntr_clear,
    output direction_t             cntr_direction,
    output logic [31:0]            cntr_start_val,
    output logic [31:0]            cntr_end_val,
    input  status_t                cntr_status,
    input  err_t                   cntr_error_status,
    input  logic [31:0]            cntr_cnt,
    output logic                   done_valid,
    input  logic                   done_ready,
    output logic [ID_W-1:0]        done_id,
    output status_t                done_status,
    output err_t                   done_err,
    output logic [31:0]            done_cnt,
    output logic                   done_timeout,
    output logic                   busy
);

    if (N_REQ < 2 || N_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("cnt_job_scheduler: parameter out of range");
    end

    sched_state_t state_q, state_d;

    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             in_idle;
    logic             run_end;
    logic             tmo_hit;

    direction_t  dir_q;
    logic [31:0] start_q;
    logic [31:0] end_q;
    logic [ID_W-1:0] id_q;
    status_t     st_q;
    err_t        err_q;
    logic [31:0] cnt_q;

    assign in_idle = (state_q == IDLE);

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    (in_idle ? req_valid : '0),
        .adv_i    (in_idle),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id)
    );

    assign run_end = (state_q == RUN) &&
                     (cntr_status == DONE || cntr_status == ERROR);

`ifdef CNT_SCHED_TIMEOUT_EN
    logic [31:0] tmr_q;
    logic        tmo_q;

    // tmr_q counts completed RUN cycles; fires once the budget is spent.
    assign tmo_hit = (state_q == RUN) && !run_end &&
                     (tmr_q == 32'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_q <= '0;
        end else if (state_q == LOAD) begin
            tmr_q <= '0;
        end else if (state_q == RUN) begin
            tmr_q <= tmr_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= 1'b0;
        end else if (state_q == LOAD || run_end) begin
            tmo_q <= 1'b0;
        end else if (tmo_hit) begin
            tmo_q <= 1'b1;
        end
    end

    assign done_timeout = tmo_q;
`else
    assign tmo_hit      = 1'b0;
    assign done_timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cntr_en    = 1'b0;
        cntr_clear = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|gnt) state_d = LOAD;
            end
            LOAD: begin
                cntr_clear = 1'b1;
                state_d = (cntr_error_status != NO_ERR) ? REPORT : RUN;
            end
            RUN: begin
                // Enable drops in the cycle the result is captured.
                if (run_end || tmo_hit) state_d = REPORT;
                else cntr_en = 1'b1;
            end
            REPORT: begin
                if (done_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q   <= UP;
            start_q <= '0;
            end_q   <= '0;
            id_q    <= '0;
            st_q    <= READY;
            err_q   <= NO_ERR;
            cnt_q   <= '0;
        end else begin
            if (in_idle && |gnt) begin
                dir_q   <= req_direction[gnt_id];
                start_q <= req_start_val[gnt_id];
                end_q   <= req_end_val[gnt_id];
                id_q    <= gnt_id;
            end
            if (state_q == LOAD && cntr_error_status != NO_ERR) begin
                st_q  <= ERROR;
                err_q <= cntr_error_status;
                cnt_q <= start_q;
            end
            if (run_end) begin
                st_q  <= cntr_status;
                err_q <= cntr_error_status;
                cnt_q <= cntr_cnt;
            end else if (tmo_hit) begin
                st_q  <= ERROR;
                err_q <= NO_ERR;
                cnt_q <= cntr_cnt;
            end
        end
    end

    assign req_ready      = in_idle ? gnt : '0;
    assign cntr_direction = dir_q;
    assign cntr_start_val = start_q;
    assign cntr_end_val   = end_q;
    assign done_valid     = (state_q == REPORT);
    assign done_id        = id_q;
    assign done_status    = st_q;
    assign done_err       = err_q;
    assign done_cnt       = cnt_q;
    assign busy           = !in_idle;

endmodule

// File: doc/cnt_job_scheduler.md
Name: cnt_job_scheduler

Overview:
- Shares one up_down_counter between N_REQ requesters.
- Each requester submits a count job (start, end, direction). The block arbitrates round-robin, latches the winning job and drives the counter's control/config inputs.
- It waits for the counter to reach DONE or ERROR, then returns a completion record through a valid/ready handshake.
- Sits between client logic and the counter instance; the counter is instantiated alongside this block, not inside it.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(N_REQ), width of the requester ID fields.
- TIMEOUT_CYCLES, 1024, RUN-state watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  N_REQ  per-requester job request.
- req_ready  out  N_REQ  one-hot grant pulse; job accepted when valid&ready.
- req_start_val  in  [N_REQ-1:0][31:0]  per-requester start value.
- req_end_val  in  [N_REQ-1:0][31:0]  per-requester end value.
- req_direction  in  [N_REQ-1:0] direction_t  per-requester direction.
- cntr_en  out  1  to counter en.
- cntr_clear  out  1  to counter clear.
- cntr_direction  out  direction_t  latched job direction.
- cntr_start_val  out  32  latched job start value.
- cntr_end_val  out  32  latched job end value.
- cntr_status  in  status_t  from counter.
- cntr_error_status  in  err_t  from counter.
- cntr_cnt  in  32  from counter.
- done_valid  out  1  completion record valid.
- done_ready  in  1  completion consumer ready.
- done_id  out  ID_W  requester that owned the job.
- done_status  out  status_t  DONE or ERROR.
- done_err  out  err_t  error class captured for the job.
- done_cnt  out  32  counter value at completion.
- done_timeout  out  1  job aborted by watchdog; tied 0 when the feature is off.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst high at posedge):
  - State goes to IDLE; round-robin pointer goes to 0.
  - All outputs go to 0: req_ready, cntr_en, cntr_clear, cntr_*_val, cntr_direction (UP), done_*, busy, done_status (READY), done_err (NO_ERR).
  - Reset mid-job abandons the job with no completion record.
- FSM states: IDLE, LOAD, RUN, REPORT.
- IDLE:
  - If any req_valid, grant the first set bit at or after the pointer (wrapping).
  - req_ready is a combinational one-hot pulse in this cycle.
  - Latch start/end/direction/ID and go to LOAD.
  - Pointer becomes (grant+1) mod N_REQ.
  - No request: stay in IDLE; req_ready stays 0.
- LOAD (1 cycle):
  - cntr_clear=1, cntr_en=0, so the counter loads start_val and goes READY.
  - Sample cntr_error_status. If not NO_ERR, go to REPORT with done_status=ERROR, done_err=sample, done_cnt=start. Otherwise go to RUN.
- RUN:
  - cntr_en=1, cntr_clear=0; config outputs held stable.
  - READY/BUSY: stay in RUN.
  - DONE or ERROR: capture cntr_status, cntr_cnt and cntr_error_status into done_* in the same cycle, drop cntr_en, go to REPORT.
- REPORT:
  - done_valid=1; done_* held stable until done_ready.
  - On done_valid&done_ready go to IDLE; a new grant is possible the following cycle, never in the same cycle.
  - cntr_en=0 in REPORT, so the counter reloads start.
- Latency: start==end (UP, 5->5) gives DONE after 1 RUN edge, so done_valid appears 4 cycles after the grant. A 5->8 UP job gives done_valid 7 cycles after the grant.
- Requesters may change or drop inputs after acceptance; the latched copy is used.
- req_ready is never asserted outside IDLE.

Optional Feature:
- Macro: CNT_SCHED_TIMEOUT_EN.
- Defined:
  - A 32-bit RUN-cycle counter clears on entry to RUN.
  - On reaching TIMEOUT_CYCLES without DONE/ERROR, go to REPORT with done_status=ERROR, done_err=NO_ERR, done_timeout=1, done_cnt=cntr_cnt.
- Undefined: no watchdog logic; done_timeout is tied 0; RUN waits indefinitely.

Decomposition:
- Package custom_package (extended), holding:
  - direction_t, status_t and err_t (existing);
  - new sched_state_t {IDLE, LOAD, RUN, REPORT};
  - localparam default_timeout = 1024.
- One sub-module: rr_arbiter (N_REQ-wide round-robin, request vector + advance strobe in, one-hot grant out).

Test Plan:
- Single job: req0 UP 5->8 -> done_valid after 7 cycles; done_id=0, done_status=DONE, done_cnt=8, done_err=NO_ERR.
- Precheck error: req1 UP start 10 end 3 -> no RUN cycle; done_status=ERROR, done_err=UP_ERR, done_cnt=10. Also DOWN 3->10 -> DOWN_ERR.
- Round-robin fairness: req0..req3 all valid continuously with 1-step jobs -> grant order 0,1,2,3,0; each done_id matches.
- Backpressure: done_ready=0 for 5 cycles -> done_* stable, req_ready stays 0, no new grant; grant occurs the cycle after the handshake.
- Reset mid-RUN: assert rst during a DOWN 100->0 job -> next cycle all outputs 0, state IDLE, no completion; a fresh job then completes normally.
- With CNT_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=8: UP 0->100 job -> done_timeout=1, done_status=ERROR after 8 RUN cycles, done_cnt=8.
